// File: rtl/alu_defs.sv
// Shared ALU / MDU definitions: ALU control codes, MDU op codes, sequencer
// state encoding and the per-iteration shift-and-add / restoring-divide steps.
package alu_defs;

   localparam int unsigned XLEN_DEF = 32;
   localparam int unsigned CTRL_W   = 4;
   localparam int unsigned CNT_W    = 5;

   // ALU control codes (the ALU decodes the same values)
   localparam logic [CTRL_W-1:0] ALU_AND   = 4'd0;
   localparam logic [CTRL_W-1:0] ALU_OR    = 4'd1;
   localparam logic [CTRL_W-1:0] ALU_NAND  = 4'd2;
   localparam logic [CTRL_W-1:0] ALU_NOR   = 4'd3;
   localparam logic [CTRL_W-1:0] ALU_ADDU  = 4'd4;
   localparam logic [CTRL_W-1:0] ALU_SUBU  = 4'd5;
   localparam logic [CTRL_W-1:0] ALU_SLT   = 4'd6;
   localparam logic [CTRL_W-1:0] ALU_EQUAL = 4'd7;

   // MDU operation codes
   localparam logic MDU_MULTU = 1'b0;
   localparam logic MDU_DIVU  = 1'b1;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mdu_state_e;

   // Operand bundle driven towards the shared ALU
   typedef struct packed {
      logic [CTRL_W-1:0]   ctrl;
      logic [XLEN_DEF-1:0] src1;
      logic [XLEN_DEF-1:0] src2;
   } alu_cmd_t;

   // Next value of the accumulator / shift register pair
   typedef struct packed {
      logic [XLEN_DEF-1:0] acc;
      logic [XLEN_DEF-1:0] q;
   } mdu_step_t;

   // One shift-and-add multiply step; res = acc + (q[0] ? m : 0)
   function automatic mdu_step_t mult_step(input logic [XLEN_DEF-1:0] acc,
                                           input logic [XLEN_DEF-1:0] q,
                                           input logic [XLEN_DEF-1:0] res);
      mdu_step_t r;
      logic      carry;
      carry = (res < acc);
      r.acc = {carry, res[XLEN_DEF-1:1]};
      r.q   = {res[0], q[XLEN_DEF-1:1]};
      return r;
   endfunction

   // One restoring-divide step; res = s - m where s = {acc, q[msb]} truncated
   function automatic mdu_step_t div_step(input logic [XLEN_DEF-1:0] acc,
                                          input logic [XLEN_DEF-1:0] q,
                                          input logic [XLEN_DEF-1:0] m,
                                          input logic [XLEN_DEF-1:0] res);
      mdu_step_t           r;
      logic [XLEN_DEF-1:0] s;
      logic                ge;
      s     = {acc[XLEN_DEF-2:0], q[XLEN_DEF-1]};
      // the shifted-out msb makes the partial remainder exceed any divisor
      ge    = acc[XLEN_DEF-1] | (s >= m);
      r.acc = ge ? res : s;
      r.q   = {q[XLEN_DEF-2:0], ge};
      return r;
   endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// Iterative MULTU/DIVU sequencer borrowing the shared ALU for one add or
// subtract per granted cycle. Only XLEN = 32 is supported.
module mdu_ctrl
   import alu_defs::*;
#(
   parameter int unsigned XLEN = XLEN_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              op_i,
   input  logic [XLEN-1:0]   src1_i,
   input  logic [XLEN-1:0]   src2_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [XLEN-1:0]   hi_o,
   output logic [XLEN-1:0]   lo_o,
   output logic              alu_req_o,
   input  logic              alu_gnt_i,
   output logic [XLEN-1:0]   alu_src1_o,
   output logic [XLEN-1:0]   alu_src2_o,
   output logic [CTRL_W-1:0] alu_ctrl_o,
   input  logic [XLEN-1:0]   alu_result_i
);

   mdu_state_e       r_state;
   mdu_state_e       w_state_nxt;
   logic [XLEN-1:0]  r_acc;
   logic [XLEN-1:0]  r_q;
   logic [XLEN-1:0]  r_m;
   logic [CNT_W-1:0] r_cnt;
   logic             r_op;

   logic             w_start_acc;
   logic             w_commit;
   logic             w_last;
   logic [XLEN-1:0]  w_s;
   alu_cmd_t         w_cmd;
   mdu_step_t        w_step;

   // A start is only honoured from IDLE or DONE; RUN ignores it
   assign w_start_acc = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   // An iteration commits only on a granted RUN cycle
   assign w_commit    = (r_state == ST_RUN) && alu_gnt_i;
   assign w_last      = (r_cnt == CNT_W'(XLEN - 1));
   assign w_s         = {r_acc[XLEN-2:0], r_q[XLEN-1]};

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and status decode
   always_comb begin
      w_state_nxt = r_state;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      alu_req_o   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start_acc) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            busy_o    = 1'b1;
            alu_req_o = 1'b1;
            if (w_commit && w_last) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done_o      = 1'b1;
            w_state_nxt = w_start_acc ? ST_RUN : ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ALU operand/opcode drive; quiet (AND of zeros) outside RUN
   always_comb begin
      w_cmd = '0;
      if (r_state == ST_RUN) begin
         if (r_op == MDU_DIVU) begin
            w_cmd.ctrl = ALU_SUBU;
            w_cmd.src1 = w_s;
            w_cmd.src2 = r_m;
         end else begin
            w_cmd.ctrl = ALU_ADDU;
            w_cmd.src1 = r_acc;
            w_cmd.src2 = r_q[0] ? r_m : '0;
         end
      end
   end

   assign alu_ctrl_o = w_cmd.ctrl;
   assign alu_src1_o = w_cmd.src1;
   assign alu_src2_o = w_cmd.src2;

   // Iteration result from the ALU's same-cycle answer
   always_comb begin
      if (r_op == MDU_DIVU) begin
         w_step = div_step(r_acc, r_q, r_m, alu_result_i);
      end else begin
         w_step = mult_step(r_acc, r_q, alu_result_i);
      end
   end

   // Datapath registers: load on accepted start, advance on commit
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_acc <= '0;
         r_q   <= '0;
         r_m   <= '0;
         r_cnt <= '0;
         r_op  <= MDU_MULTU;
      end else if (w_start_acc) begin
         r_acc <= '0;
         r_q   <= src1_i;
         r_m   <= src2_i;
         r_cnt <= '0;
         r_op  <= op_i;
      end else if (w_commit) begin
         r_acc <= w_step.acc;
         r_q   <= w_step.q;
         r_cnt <= CNT_W'(r_cnt + CNT_W'(1));
      end
   end

   assign hi_o = r_acc;
   assign lo_o = r_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed vector table plus randomized operations
// checked against plain 64-bit arithmetic, with an ALU model in the loop.
module tb_mdu_ctrl;
   import alu_defs::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        op_i;
   logic [31:0] src1_i;
   logic [31:0] src2_i;
   logic        busy_o;
   logic        done_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        alu_req_o;
   logic        alu_gnt_i;
   logic [31:0] alu_src1_o;
   logic [31:0] alu_src2_o;
   logic [3:0]  alu_ctrl_o;
   logic [31:0] alu_result_i;

   int n_vec = 0;
   int n_err = 0;

   mdu_ctrl #(.XLEN(32)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .op_i         (op_i),
      .src1_i       (src1_i),
      .src2_i       (src2_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .hi_o         (hi_o),
      .lo_o         (lo_o),
      .alu_req_o    (alu_req_o),
      .alu_gnt_i    (alu_gnt_i),
      .alu_src1_o   (alu_src1_o),
      .alu_src2_o   (alu_src2_o),
      .alu_ctrl_o   (alu_ctrl_o),
      .alu_result_i (alu_result_i)
   );

   always #5 clk_i = ~clk_i;

   // Combinational ALU as seen at CPU top level
   always_comb begin
      case (alu_ctrl_o)
         4'd0:    alu_result_i = alu_src1_o & alu_src2_o;
         4'd1:    alu_result_i = alu_src1_o | alu_src2_o;
         4'd2:    alu_result_i = ~(alu_src1_o & alu_src2_o);
         4'd3:    alu_result_i = ~(alu_src1_o | alu_src2_o);
         4'd4:    alu_result_i = alu_src1_o + alu_src2_o;
         4'd5:    alu_result_i = alu_src1_o - alu_src2_o;
         4'd6:    alu_result_i = {31'd0, $signed(alu_src1_o) < $signed(alu_src2_o)};
         4'd7:    alu_result_i = {31'd0, alu_src1_o == alu_src2_o};
         default: alu_result_i = 32'd0;
      endcase
   end

   typedef struct {
      string       name;
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      int          gmode;   // 0 = always grant, 1 = toggle from 1, 2 = random
      int          pulse;   // RUN cycle at which a stray start is pulsed, 0 = none
      logic        b2b;     // next vector starts in this vector's DONE cycle
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   // Start an operation in the current (IDLE or DONE) cycle and follow it to DONE
   task automatic run_op(input string name, input logic op, input logic [31:0] a,
                         input logic [31:0] b, input int gmode, input int pulse,
                         input logic [31:0] ehi, input logic [31:0] elo);
      int   grants;
      int   cyc;
      logic g;
      start_i = 1'b1;
      op_i    = op;
      src1_i  = a;
      src2_i  = b;
      tick();
      start_i = 1'b0;
      op_i    = ~op;
      src1_i  = $urandom;
      src2_i  = $urandom;
      grants  = 0;
      cyc     = 1;
      while (grants < 32 && cyc < 200) begin
         case (gmode)
            0:       g = 1'b1;
            1:       g = ((cyc % 2) == 1);
            default: g = ($urandom_range(3) != 0);
         endcase
         alu_gnt_i = g;
         if (cyc == pulse) begin
            start_i = 1'b1;
            op_i    = ~op;
            src1_i  = 32'hDEAD_BEEF;
            src2_i  = 32'h0000_0003;
         end else begin
            start_i = 1'b0;
         end
         chk({name, ".run_busy"}, 64'(busy_o), 64'(1));
         chk({name, ".run_done"}, 64'(done_o), 64'(0));
         chk({name, ".run_req"},  64'(alu_req_o), 64'(1));
         chk({name, ".run_ctrl"}, 64'(alu_ctrl_o), (op == MDU_DIVU) ? 64'(5) : 64'(4));
         tick();
         if (g) grants++;
         cyc++;
      end
      start_i   = 1'b0;
      alu_gnt_i = 1'($urandom_range(1));
      chk({name, ".done"},  64'(done_o), 64'(1));
      chk({name, ".busy"},  64'(busy_o), 64'(0));
      chk({name, ".req"},   64'(alu_req_o), 64'(0));
      chk({name, ".ctrl"},  64'(alu_ctrl_o), 64'(0));
      chk({name, ".src"},   {alu_src1_o, alu_src2_o}, 64'(0));
      chk({name, ".hi"},    64'(hi_o), 64'(ehi));
      chk({name, ".lo"},    64'(lo_o), 64'(elo));
   endtask

   // One cycle after DONE without a start: IDLE, results held
   task automatic idle_check(input string name, input logic [31:0] ehi, input logic [31:0] elo);
      tick();
      chk({name, ".idle_done"}, 64'(done_o), 64'(0));
      chk({name, ".idle_busy"}, 64'(busy_o), 64'(0));
      chk({name, ".idle_hilo"}, {hi_o, lo_o}, {ehi, elo});
   endtask

   initial begin
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] p;
      logic [31:0] ehi;
      logic [31:0] elo;

      vecs[0] = '{"mul_3x5",      1'b0, 32'd3,          32'd5,          0, 0, 1'b0, 32'h0,        32'hF};
      vecs[1] = '{"mul_max",      1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, 0, 1'b0, 32'hFFFF_FFFE, 32'h1};
      vecs[2] = '{"div_100_7",    1'b1, 32'd100,        32'd7,          0, 0, 1'b1, 32'd2,        32'd14};
      vecs[3] = '{"div_msb",      1'b1, 32'h8000_0000,  32'd3,          0, 0, 1'b0, 32'd2,        32'h2AAA_AAAA};
      vecs[4] = '{"div_by_zero",  1'b1, 32'h1234_5678,  32'd0,          0, 0, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF};
      vecs[5] = '{"mul_toggle",   1'b0, 32'd3,          32'd5,          1, 0, 1'b0, 32'h0,        32'hF};
      vecs[6] = '{"mul_stray_st", 1'b0, 32'd3,          32'd5,          0, 5, 1'b0, 32'h0,        32'hF};

      rst_i     = 1'b1;
      start_i   = 1'b0;
      op_i      = 1'b0;
      src1_i    = 32'd0;
      src2_i    = 32'd0;
      alu_gnt_i = 1'b0;
      tick();
      tick();
      chk("reset.status", {62'd0, busy_o, done_o}, 64'd0);
      chk("reset.hilo",   {hi_o, lo_o}, 64'd0);
      chk("reset.alu",    {alu_src1_o, alu_src2_o}, 64'd0);
      chk("reset.ctrl",   64'({alu_req_o, alu_ctrl_o}), 64'd0);
      rst_i = 1'b0;

      // grant outside RUN must not matter
      alu_gnt_i = 1'b1;
      tick();
      chk("idle.busy", 64'(busy_o), 64'd0);
      chk("idle.hilo", {hi_o, lo_o}, 64'd0);

      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].gmode,
                vecs[i].pulse, vecs[i].hi, vecs[i].lo);
         if (!vecs[i].b2b) idle_check(vecs[i].name, vecs[i].hi, vecs[i].lo);
      end

      // reset asserted in RUN cycle 10 wipes everything
      start_i   = 1'b1;
      op_i      = 1'b0;
      src1_i    = 32'hFFFF_FFFF;
      src2_i    = 32'hFFFF_FFFF;
      alu_gnt_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int c = 1; c < 10; c++) tick();
      chk("midrst.busy_before", 64'(busy_o), 64'd1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("midrst.status", {62'd0, busy_o, done_o}, 64'd0);
      chk("midrst.hilo",   {hi_o, lo_o}, 64'd0);
      chk("midrst.alu",    {alu_src1_o, alu_src2_o}, 64'd0);
      chk("midrst.ctrl",   64'({alu_req_o, alu_ctrl_o}), 64'd0);
      tick();
      chk("midrst.idle", {62'd0, busy_o, done_o}, 64'd0);

      // randomized operations against plain arithmetic
      for (int k = 0; k < 24; k++) begin
         op = 1'($urandom_range(1));
         a  = $urandom;
         if (k % 5 == 0)      b = 32'd0;
         else if (k % 3 == 0) b = 32'($urandom_range(255, 1));
         else                 b = $urandom;
         if (op == MDU_MULTU) begin
            p   = {32'd0, a} * {32'd0, b};
            ehi = p[63:32];
            elo = p[31:0];
         end else if (b == 32'd0) begin
            ehi = a;
            elo = 32'hFFFF_FFFF;
         end else begin
            ehi = a % b;
            elo = a / b;
         end
         run_op($sformatf("rnd%0d", k), op, a, b, 2, $urandom_range(40, 1), ehi, elo);
         if ($urandom_range(1) == 0) idle_check($sformatf("rnd%0d", k), ehi, elo);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
